// File: rtl/maf_norm_seq.sv
// Multi-cycle normalizer: one shared 32-bit leading-one detector scans the upper
// then the lower mantissa half, then a single shift/exponent-adjust step clamps at zero.
module maf_norm_seq #(
  parameter int EXP_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_mant,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_mant,
  output logic [EXP_W-1:0] out_exp,
  output logic [6:0]       out_lz,
  output logic             out_zero,
  output logic             out_uflow,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, SCAN_HI, SCAN_LO, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [63:0]      mant_q, mant_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [6:0]       lz_q, lz_d;
  logic [63:0]      out_mant_q, out_mant_d;
  logic [EXP_W-1:0] out_exp_q, out_exp_d;
  logic [6:0]       out_lz_q, out_lz_d;
  logic             out_zero_q, out_zero_d;
  logic             out_uflow_q, out_uflow_d;

  logic [31:0]      det_f;
  logic             det_v;
  logic [4:0]       det_lz;
  logic [EXP_W-1:0] lz_ext;
  logic [EXP_W-1:0] sh;

  // Shared detector: the last (highest) set bit seen in the loop wins.
  always_comb begin
    det_f  = (state_q == SCAN_LO) ? mant_q[31:0] : mant_q[63:32];
    det_v  = |det_f;
    det_lz = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (det_f[i]) det_lz = 5'(31 - i);
    end
  end

  assign lz_ext = EXP_W'(lz_q);
  assign sh     = (lz_ext > exp_q) ? exp_q : lz_ext;

  always_comb begin
    state_d     = state_q;
    mant_d      = mant_q;
    exp_d       = exp_q;
    lz_d        = lz_q;
    out_mant_d  = out_mant_q;
    out_exp_d   = out_exp_q;
    out_lz_d    = out_lz_q;
    out_zero_d  = out_zero_q;
    out_uflow_d = out_uflow_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mant_d  = in_mant;
            exp_d   = in_exp;
            state_d = SCAN_HI;
          end
        end
        SCAN_HI: begin
          if (det_v) begin
            lz_d    = {2'b00, det_lz};
            state_d = SHIFT;
          end else begin
            state_d = SCAN_LO;
          end
        end
        SCAN_LO: begin
          if (det_v) begin
            lz_d    = 7'd32 + {2'b00, det_lz};
            state_d = SHIFT;
          end else begin
            lz_d        = 7'd64;
            out_lz_d    = 7'd64;
            out_zero_d  = 1'b1;
            out_mant_d  = 64'd0;
            out_exp_d   = '0;
            out_uflow_d = 1'b0;
            state_d     = DONE;
          end
        end
        SHIFT: begin
          out_mant_d  = mant_q << sh;
          out_exp_d   = exp_q - sh;
          out_uflow_d = (lz_ext > exp_q);
          out_lz_d    = lz_q;
          out_zero_d  = 1'b0;
          state_d     = DONE;
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mant_q      <= 64'd0;
      exp_q       <= '0;
      lz_q        <= 7'd0;
      out_mant_q  <= 64'd0;
      out_exp_q   <= '0;
      out_lz_q    <= 7'd0;
      out_zero_q  <= 1'b0;
      out_uflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mant_q      <= mant_d;
      exp_q       <= exp_d;
      lz_q        <= lz_d;
      out_mant_q  <= out_mant_d;
      out_exp_q   <= out_exp_d;
      out_lz_q    <= out_lz_d;
      out_zero_q  <= out_zero_d;
      out_uflow_q <= out_uflow_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_mant  = out_mant_q;
  assign out_exp   = out_exp_q;
  assign out_lz    = out_lz_q;
  assign out_zero  = out_zero_q;
  assign out_uflow = out_uflow_q;

endmodule

// File: tb/tb_maf_norm_seq.sv
// Directed bench for maf_norm_seq: vector table plus backpressure, flush and reset sequences.
module tb_maf_norm_seq;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_zero, out_uflow, busy;
  logic [63:0] in_mant, out_mant;
  logic [9:0]  in_exp, out_exp;
  logic [6:0]  out_lz;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  maf_norm_seq #(.EXP_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mant(in_mant), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant), .out_exp(out_exp),
    .out_lz(out_lz), .out_zero(out_zero), .out_uflow(out_uflow), .busy(busy)
  );

  typedef struct {
    logic [63:0] mant;
    logic [9:0]  exp;
    logic [63:0] emant;
    logic [9:0]  eexp;
    logic [6:0]  elz;
    logic        ezero;
    logic        euflow;
    int          lat;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Called right after the accept edge (+1); counts edges until out_valid.
  task automatic wait_result(input vec_t v, input bit rel);
    int cycles = 0;
    while (!out_valid && cycles < 8) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk("latency", 64'(cycles), 64'(v.lat));
    chk("out_mant", out_mant, v.emant);
    chk("out_exp", 64'(out_exp), 64'(v.eexp));
    chk("out_lz", 64'(out_lz), 64'(v.elz));
    chk("out_zero", 64'(out_zero), 64'(v.ezero));
    chk("out_uflow", 64'(out_uflow), 64'(v.euflow));
    chk("in_ready_done", 64'(in_ready), 64'd0);
    if (rel) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("release_valid", 64'(out_valid), 64'd0);
      chk("release_ready", 64'(in_ready), 64'd1);
    end
  endtask

  task automatic do_op(input vec_t v, input bit rel);
    in_valid = 1'b1;
    in_mant  = v.mant;
    in_exp   = v.exp;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'd1);
    wait_result(v, rel);
    $display("op mant=%h exp=%0d -> mant=%h exp=%0d lz=%0d z=%0d uf=%0d",
             v.mant, v.exp, out_mant, out_exp, out_lz, out_zero, out_uflow);
  endtask

  initial begin
    vt[0] = '{64'h0000_0400_0000_0000, 10'd100, 64'h8000_0000_0000_0000, 10'd79,  7'd21, 1'b0, 1'b0, 2};
    vt[1] = '{64'h0000_0000_0000_0003, 10'd100, 64'hC000_0000_0000_0000, 10'd38,  7'd62, 1'b0, 1'b0, 3};
    vt[2] = '{64'h0000_0000_0000_0003, 10'd10,  64'h0000_0000_0000_0C00, 10'd0,   7'd62, 1'b0, 1'b1, 3};
    vt[3] = '{64'h0000_0000_0000_0000, 10'd55,  64'h0000_0000_0000_0000, 10'd0,   7'd64, 1'b1, 1'b0, 2};
    vt[4] = '{64'h8000_0000_0000_0001, 10'd7,   64'h8000_0000_0000_0001, 10'd7,   7'd0,  1'b0, 1'b0, 2};
    vt[5] = '{64'h0000_0001_0000_0000, 10'd0,   64'h0000_0001_0000_0000, 10'd0,   7'd31, 1'b0, 1'b1, 2};
    vt[6] = '{64'h0000_0000_8000_0000, 10'd40,  64'h8000_0000_0000_0000, 10'd8,   7'd32, 1'b0, 1'b0, 3};
    vt[7] = '{64'h0000_0000_0001_0000, 10'd47,  64'h8000_0000_0000_0000, 10'd0,   7'd47, 1'b0, 1'b0, 3};
    vt[8] = '{64'h0F00_0000_0000_0000, 10'd1023, 64'hF000_0000_0000_0000, 10'd1019, 7'd4, 1'b0, 1'b0, 2};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_mant = 64'd0; in_exp = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_mant", out_mant, 64'd0);
    chk("rst_out_lz", 64'(out_lz), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) do_op(vt[i], 1'b1);

    // Backpressure: a second request is held high while the first result waits.
    do_op(vt[0], 1'b0);
    in_valid = 1'b1;
    in_mant  = vt[4].mant;
    in_exp   = vt[4].exp;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_mant", out_mant, vt[0].emant);
      chk("bp_exp", 64'(out_exp), 64'(vt[0].eexp));
      $display("bp cycle %0d out_valid=%0d in_ready=%0d", k, out_valid, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_accept", 64'(busy), 64'd1);
    wait_result(vt[4], 1'b1);
    $display("bp second op lz=%0d mant=%h", out_lz, out_mant);

    // Flush in SCAN_LO: result registers keep the previous result (vt[4]).
    in_valid = 1'b1;
    in_mant  = vt[1].mant;
    in_exp   = vt[1].exp;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_out_lz_kept", 64'(out_lz), 64'(vt[4].elz));
    chk("flush_out_mant_kept", out_mant, vt[4].emant);
    for (int k = 0; k < 4; k++) begin
      chk("flush_no_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    $display("flush done in_ready=%0d out_valid=%0d", in_ready, out_valid);

    // Reset while in SHIFT.
    in_valid = 1'b1;
    in_mant  = vt[0].mant;
    in_exp   = vt[0].exp;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_mant", out_mant, 64'd0);
    chk("arst_out_exp", 64'(out_exp), 64'd0);
    chk("arst_out_lz", 64'(out_lz), 64'd0);
    in_valid = 1'b1;
    in_mant  = vt[2].mant;
    in_exp   = vt[2].exp;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("arst_ignore_input", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(vt[1], 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/maf_norm_seq.md
# maf_norm_seq

Multi-cycle normalization sequencer for the MAF post-adder path. It accepts a 64-bit unnormalized mantissa and its biased exponent through a valid/ready handshake. It time-shares one 32-bit leading-one detector across the upper and lower halves to find the leading-zero count, then left-shifts and adjusts the exponent, clamping at exponent zero. The normalized result is presented on a valid/ready output port to the rounding stage.

## Interface
- EXP_W, 10, biased exponent width (unsigned)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort; drops any in-flight operation
- in_valid  in  1  input request
- in_ready  out  1  block can accept; equals (state==IDLE)
- in_mant  in  64  unnormalized mantissa
- in_exp  in  EXP_W  biased exponent
- out_valid  out  1  result available; equals (state==DONE)
- out_ready  in  1  downstream accepts result
- out_mant  out  64  normalized mantissa
- out_exp  out  EXP_W  adjusted exponent
- out_lz  out  7  leading-zero count of in_mant (0..64)
- out_zero  out  1  in_mant was zero
- out_uflow  out  1  shift clamped by exponent (lz > in_exp)
- busy  out  1  state != IDLE

## Operation
- Single shared 32-bit leading-one detector. Contract: input F[31:0]; output V = |F; output lz5 = count of leading zeros from F[31] (valid when V=1). The detector's mux input is the upper half of mant_r in SCAN_HI and the lower half in SCAN_LO.
- States: IDLE, SCAN_HI, SCAN_LO, SHIFT, DONE.
- IDLE: on in_valid && in_ready && !flush, latch mant_r and exp_r, then go to SCAN_HI.
- SCAN_HI: the detector sees mant_r[63:32]. If V=1, set lz_r = lz5 and go to SHIFT. Otherwise go to SCAN_LO.
- SCAN_LO: the detector sees mant_r[31:0]. If V=1, set lz_r = 32 + lz5 and go to SHIFT. Otherwise set lz_r = 64 and go to DONE with out_zero=1, out_mant=0, out_exp=0, out_uflow=0.
- SHIFT:
  - sh = min(lz_r, exp_r), compared at full width and zero-extended.
  - out_mant = mant_r << sh (64-bit, zero fill). out_exp = exp_r − sh. out_uflow = (lz_r > exp_r). out_lz = lz_r.
  - Go to DONE.
- DONE: hold all outputs stable. On out_ready, go to IDLE. There is no accept in the same cycle; in_ready is low in DONE.
- flush: the next edge forces IDLE from any state. Output registers are unchanged but out_valid drops. flush has priority over both handshakes.
- Output registers update only on the SHIFT→DONE and SCAN_LO→DONE transitions.
- rst_n low: state=IDLE immediately (async). mant_r, exp_r, lz_r, out_mant, out_exp, out_lz, out_zero and out_uflow are all 0. Resulting reset values: out_valid=0, busy=0, in_ready=1. Inputs are ignored while rst_n is low.

## Timing
- Edge E0 is the accept edge.
  - Upper-half hit: SCAN_HI@E0, SHIFT@E1, DONE@E2. out_valid is high after E2 (2-edge latency).
  - Lower-half hit: DONE@E3 (3-edge latency).
  - Zero mantissa: DONE@E2.
- Throughput is at most one operation per 4 cycles (upper-half hit, out_ready tied high, includes the IDLE cycle).
- in_valid during a non-IDLE state is ignored. The requester must hold its data until in_ready.
- out_valid stays high until a cycle with out_ready=1. Outputs must not change while out_valid=1.
- Reset asserted mid-operation: the operation is discarded. out_valid is low from the assertion onward.
- Edge cases:
  - exp_r=0 with nonzero mantissa: sh=0, out_mant=mant_r, out_uflow=1 (if lz>0).
  - lz=0 (bit 63 set): out_mant=in_mant, out_exp=in_exp, out_uflow=0.

## Test plan
- Upper-half hit: in_mant=0x0000_0400_0000_0000, in_exp=100 → at E2, out_valid=1, out_lz=21, out_mant=0x8000_0000_0000_0000, out_exp=79, out_uflow=0, out_zero=0.
- Lower-half hit: in_mant=0x0000_0000_0000_0003, in_exp=100 → at E3, out_lz=62, out_mant=0xC000_0000_0000_0000, out_exp=38.
- Underflow clamp: in_mant=0x3, in_exp=10 → out_lz=62, out_mant=0x0C00, out_exp=0, out_uflow=1.
- Zero and already-normal inputs:
  - in_mant=0, in_exp=55 → at E2, out_zero=1, out_lz=64, out_mant=0, out_exp=0.
  - in_mant=0x8000_0000_0000_0001, in_exp=7 → out_lz=0, outputs equal inputs.
- Backpressure: hold out_ready=0 for 5 cycles after DONE → outputs are stable and in_ready=0 throughout. A second in_valid is ignored until the cycle after out_ready=1.
- Abort and reset:
  - Assert flush in SCAN_LO → IDLE next edge, out_valid never rises, in_ready=1.
  - Drop rst_n in SHIFT → out_valid=0 and all outputs 0 immediately. The first operation after release completes correctly.
